// File: rtl/status_flag_unit.sv
// NZCV status-flag register: evaluates the flags of the executing ALU class
// and commits them one cycle later unless the instruction is stalled or squashed.
module status_flag_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        flag_en,
   input  logic        freeze,
   input  logic        flush,
   input  logic [3:0]  exe_cmd,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        shift_carry,
   output logic [3:0]  nzcv,
   output logic [3:0]  nzcv_next,
   output logic        upd_pulse
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;

   logic [3:0] flags;
   logic       op_valid;
   logic       commit;

   // Returns {class_is_flag_producing, N, Z, C, V}; old carry always comes from the register.
   function automatic logic [4:0] eval_flags(
      input logic [3:0]  cmd,
      input logic [31:0] a,
      input logic [31:0] b,
      input logic        sc,
      input logic [3:0]  old
   );
      logic [32:0] sum;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        known;
      sum   = '0;
      res   = '0;
      c     = sc;
      v     = old[0];
      known = 1'b1;
      case (cmd)
         CMD_ADD, CMD_ADC: begin
            sum = {1'b0, a} + {1'b0, b} + {32'd0, (cmd == CMD_ADC) & old[1]};
            res = sum[31:0];
            c   = sum[32];
            v   = (a[31] == b[31]) && (res[31] != a[31]);
         end
         CMD_SUB, CMD_SBC: begin
            // Bit 32 of the 33-bit difference is the borrow; C is its inverse.
            sum = {1'b0, a} - {1'b0, b} - {32'd0, (cmd == CMD_SBC) & ~old[1]};
            res = sum[31:0];
            c   = ~sum[32];
            v   = (a[31] != b[31]) && (res[31] != a[31]);
         end
         CMD_MOV: res = b;
         CMD_MVN: res = ~b;
         CMD_AND: res = a & b;
         CMD_ORR: res = a | b;
         CMD_EOR: res = a ^ b;
         default: known = 1'b0;
      endcase
      return {known, res[31], (res == 32'd0), c, v};
   endfunction

   always_comb begin
      {op_valid, flags} = eval_flags(exe_cmd, op_a, op_b, shift_carry, nzcv);
      commit            = flag_en & ~freeze & ~flush & op_valid;
      nzcv_next         = commit ? flags : nzcv;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nzcv      <= 4'b0000;
         upd_pulse <= 1'b0;
      end else begin
         upd_pulse <= commit;
         if (commit)
            nzcv <= flags;
      end
   end

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed vector table, reset corner sequence,
// then random traffic against an integer-arithmetic reference model.
module tb_status_flag_unit;

   logic        clk;
   logic        rst;
   logic        flag_en;
   logic        freeze;
   logic        flush;
   logic [3:0]  exe_cmd;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        shift_carry;
   logic [3:0]  nzcv;
   logic [3:0]  nzcv_next;
   logic        upd_pulse;

   int n_checks;
   int n_fail;

   status_flag_unit dut (
      .clk         (clk),
      .rst         (rst),
      .flag_en     (flag_en),
      .freeze      (freeze),
      .flush       (flush),
      .exe_cmd     (exe_cmd),
      .op_a        (op_a),
      .op_b        (op_b),
      .shift_carry (shift_carry),
      .nzcv        (nzcv),
      .nzcv_next   (nzcv_next),
      .upd_pulse   (upd_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic        sc;
      logic        en;
      logic        frz;
      logic        fl;
      logic [3:0]  exp_nzcv;
      logic        exp_upd;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                               input logic sc, input logic en, input logic frz, input logic fl,
                               input logic [3:0] e_nzcv, input logic e_upd);
      vec_t v;
      v.cmd = cmd; v.a = a; v.b = b; v.sc = sc; v.en = en; v.frz = frz; v.fl = fl;
      v.exp_nzcv = e_nzcv; v.exp_upd = e_upd;
      return v;
   endfunction

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Reference: flags from integer arithmetic and signed range tests.
   function automatic logic [4:0] ref_flags(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b, input logic sc,
                                            input logic [3:0] old);
      longint ua, ub, sa, sb, full, sres;
      logic [31:0] res;
      logic c, v, cin;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = 32'd0; c = sc; v = old[0];
      case (cmd)
         4'd2, 4'd3: begin
            cin  = (cmd == 4'd3) ? old[1] : 1'b0;
            full = ua + ub + longint'(cin);
            res  = full[31:0];
            c    = (full > 64'sd4294967295);
            sres = sa + sb + longint'(cin);
            v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            cin  = (cmd == 4'd5) ? !old[1] : 1'b0;
            c    = (ua >= ub + longint'(cin));
            full = ua - ub - longint'(cin);
            res  = full[31:0];
            sres = sa - sb - longint'(cin);
            v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
         end
         4'd1: res = b;
         4'd9: res = ~b;
         4'd6: res = a & b;
         4'd7: res = a | b;
         4'd8: res = a ^ b;
         default: return {1'b0, old};
      endcase
      return {1'b1, res[31], (res == 32'd0), c, v};
   endfunction

   task automatic drive(input vec_t v);
      exe_cmd = v.cmd; op_a = v.a; op_b = v.b; shift_carry = v.sc;
      flag_en = v.en; freeze = v.frz; flush = v.fl;
   endtask

   // Called just after a falling edge; ends just after the next falling edge.
   task automatic step(input vec_t v, input string tag);
      drive(v);
      #2;
      check4({tag, " nzcv_next"}, nzcv_next, v.exp_nzcv);
      @(posedge clk);
      #1;
      check4({tag, " nzcv"}, nzcv, v.exp_nzcv);
      check1({tag, " upd_pulse"}, upd_pulse, v.exp_upd);
      @(negedge clk);
   endtask

   logic [3:0] m_nzcv;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      drive(mk(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));

      tbl[0]  = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b1);
      tbl[1]  = mk(4'd4, 32'd5,        32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1);
      tbl[2]  = mk(4'd4, 32'd0,        32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
      tbl[3]  = mk(4'd2, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1);
      tbl[4]  = mk(4'd3, 32'd0,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
      tbl[5]  = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b1);
      tbl[6]  = mk(4'd6, 32'hF0,       32'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b1);
      tbl[7]  = mk(4'd0, 32'd3,        32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b0);
      tbl[8]  = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0);
      tbl[9]  = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0);
      tbl[10] = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0);
      tbl[11] = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b1);
      tbl[12] = mk(4'd4, 32'd5,        32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1);
      tbl[13] = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
      tbl[14] = mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
      tbl[15] = mk(4'd4, 32'd0,        32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
      tbl[16] = mk(4'd5, 32'd5,        32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
      tbl[17] = mk(4'd5, 32'd6,        32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1);
      tbl[18] = mk(4'd9, 32'd0,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
      tbl[19] = mk(4'd7, 32'd0,        32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1);
      tbl[20] = mk(4'd8, 32'h80000000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
      tbl[21] = mk(4'd4, 32'h80000000, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b1);
      tbl[22] = mk(4'd1, 32'd7,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b1);

      // Reset state, with a clock running underneath.
      repeat (3) @(posedge clk);
      #1;
      check4("reset nzcv", nzcv, 4'b0000);
      check1("reset upd_pulse", upd_pulse, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 23; i++)
         step(tbl[i], $sformatf("row%0d", i));

      // Asynchronous reset mid-cycle discards a pending commit.
      step(mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b1), "pre_rst");
      drive(mk(4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
      #2;
      rst = 1'b0;
      #1;
      check4("async rst nzcv", nzcv, 4'b0000);
      check1("async rst upd", upd_pulse, 1'b0);
      @(posedge clk);
      #1;
      check4("rst hold nzcv", nzcv, 4'b0000);
      check1("rst hold upd", upd_pulse, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      check4("release edge nzcv", nzcv, 4'b0000);
      check1("release edge upd", upd_pulse, 1'b0);
      @(posedge clk);
      #1;
      check4("post release nzcv", nzcv, 4'b1001);
      check1("post release upd", upd_pulse, 1'b1);
      @(negedge clk);

      // Random traffic against the reference model.
      m_nzcv = 4'b1001;
      for (int i = 0; i < 400; i++) begin
         vec_t v;
         logic [4:0] r;
         logic [31:0] pick[4];
         pick[0] = $urandom;
         pick[1] = 32'hFFFFFFFF;
         pick[2] = 32'h80000000;
         pick[3] = $urandom_range(0, 3);
         v.cmd = 4'($urandom_range(0, 15));
         v.a   = pick[$urandom_range(0, 3)];
         v.b   = (i % 3 == 0) ? v.a : pick[$urandom_range(0, 3)];
         v.sc  = 1'($urandom_range(0, 1));
         v.en  = ($urandom_range(0, 3) != 0);
         v.frz = ($urandom_range(0, 5) == 0);
         v.fl  = ($urandom_range(0, 5) == 0);
         r = ref_flags(v.cmd, v.a, v.b, v.sc, m_nzcv);
         v.exp_upd  = r[4] && v.en && !v.frz && !v.fl;
         v.exp_nzcv = v.exp_upd ? r[3:0] : m_nzcv;
         step(v, $sformatf("rand%0d", i));
         m_nzcv = v.exp_nzcv;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/status_flag_unit.md
STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 The module SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flag_en  in  1  S-bit of the executing instruction, qualified valid.
- freeze  in  1  pipeline stall; the current instruction will be replayed.
- flush  in  1  current instruction squashed (branch taken).
- exe_cmd  in  4  flag-producing operation class: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB/CMP, 0101 SBC, 0110 AND/TST, 0111 ORR, 1000 EOR; other codes are NOP.
- op_a  in  32  first operand (Rn value).
- op_b  in  32  second operand (shifter output).
- shift_carry  in  1  shifter carry-out, used by logical classes.
- nzcv  out  4  registered status flags, {N,Z,C,V} at bits [3:0], fed to condition evaluation.
- nzcv_next  out  4  bypass value: flags that will be visible after the next edge.
- upd_pulse  out  1  registered; high for one cycle after each committed flag update.

Function
REQ-002 The unit SHALL compute the 32-bit result internally: MOV=op_b, MVN=~op_b, ADD=a+b, ADC=a+b+C, SUB=a-b, SBC=a-b-!C, AND=a&b, ORR=a|b, EOR=a^b, where C is the registered nzcv[1].
- Arithmetic SHALL use a 33-bit sum; bit 32 is the carry.
REQ-003 N SHALL equal result[31], and Z SHALL be 1 iff result==0, for every non-NOP class.
REQ-004 For ADD/ADC, C SHALL be the carry-out of the 33-bit sum.
- V SHALL be (a[31]==b[31]) && (res[31]!=a[31]).
REQ-005 For SUB/SBC, C SHALL be NOT-borrow: SUB C=1 iff a>=b unsigned; SBC C=1 iff a >= b+!C_old, evaluated in 33 bits.
- V SHALL be (a[31]!=b[31]) && (res[31]!=a[31]).
REQ-006 For MOV/MVN/AND/ORR/EOR, C SHALL equal shift_carry and V SHALL retain its old value.
REQ-007 Commit condition SHALL be: flag_en && !freeze && !flush && exe_cmd not NOP.
- On commit, nzcv SHALL load the computed flags at the rising edge.
- Latency SHALL be one cycle.
REQ-008 Without commit, nzcv SHALL hold its value.
- flush SHALL override flag_en and SHALL prevent any update.
- freeze SHALL prevent any update; the replayed instruction commits on the first cycle without freeze.
REQ-009 nzcv_next SHALL be combinational: the computed flags when the commit condition holds, otherwise nzcv.
REQ-010 upd_pulse SHALL be 1 in the cycle after a commit, otherwise 0.
- Back-to-back commits SHALL hold upd_pulse at 1 on consecutive cycles.
REQ-011 The old C used by ADC/SBC SHALL always be the registered value, never nzcv_next.
- Consecutive ADC operations SHALL chain the carry correctly across cycles.
REQ-012 All 32-bit wrap-around SHALL be modulo 2^32, with no saturation.

Reset
REQ-013 While rst=0, nzcv SHALL be 4'b0000 and upd_pulse SHALL be 0, asynchronously, independent of clk.
REQ-014 If reset is asserted mid-operation, a commit pending in that cycle SHALL be discarded.
- The first commit after reset release SHALL occur no earlier than the first rising edge with rst=1.
REQ-015 During reset, nzcv_next SHALL equal 4'b0000 unless the commit condition is true.
- Its value during reset is otherwise don't-care for verification.

Verification
REQ-016 Bench SHALL cover these directed scenarios, each as stimulus -> required response.
- ADD with op_a=0x7FFFFFFF, op_b=0x00000001, flag_en=1 -> next cycle nzcv=4'b1001, upd_pulse=1.
- SUB with op_a=5, op_b=5 -> nzcv=4'b0110; then SUB with op_a=0, op_b=1 -> nzcv=4'b1000.
- ADD with op_a=0xFFFFFFFF, op_b=1 (nzcv=0110), then ADC with op_a=0, op_b=0 next cycle -> nzcv=4'b0000 after ADC.
  - Result=1 with carry consumed.
- AND with op_a=0xF0, op_b=0x0F, shift_carry=1, V previously 1 -> nzcv=4'b0111.
- ADD overflow case (op_a=0x7FFFFFFF, op_b=0x00000001) with freeze=1 for 2 cycles -> nzcv unchanged and upd_pulse=0.
  - Then freeze=0 -> nzcv=1001 one cycle later.
  - Same stimulus with flush=1 -> nzcv unchanged.
- After nzcv=1001, assert rst=0 between edges -> nzcv=0000 immediately.
  - Commit with flag_en=1 on the release edge -> nzcv=0000 on that edge, update on the following edge.
